axi_lite_regbank: RTL

Parametrised AXI4-Lite slave register bank, the next generation of our fixed four-register S00_AXI peripheral. It provides NUM_REGS read/write control registers and NUM_STATUS read-only status registers, with byte-lane strobes, SLVERR on unmapped addresses, and per-register write strobes to user logic. It sits behind the AXI interconnect at the S00_AXI port of each lab IP, and the AXI VIP master testbench drives it.

---
 rtl/axi_lite_regbank.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lite_regbank                                                           |
// | AXI4-Lite slave: NUM_REGS R/W control regs, NUM_STATUS read-only regs.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi_lite_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 8,
  parameter int NUM_STATUS         = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_REGS-1:0]                    ctrl_wr,
  input  logic [((NUM_STATUS > 0) ? NUM_STATUS : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in
);

  localparam int          c_DW       = C_S_AXI_DATA_WIDTH;
  localparam int          c_SW       = C_S_AXI_DATA_WIDTH / 8;
  localparam int          c_ADDR_LSB = $clog2(c_SW);
  localparam logic [31:0] c_NMAP     = 32'(NUM_REGS + NUM_STATUS);
  localparam logic [1:0]  c_OKAY     = 2'b00;
  localparam logic [1:0]  c_SLVERR   = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic [c_DW-1:0]     r_ctrl [NUM_REGS];
  logic [NUM_REGS-1:0] r_ctrl_wr;
  logic                r_awready, r_wready, r_bvalid;
  logic [1:0]          r_bresp;
  logic [31:0]         r_widx;
  logic [c_DW-1:0]     r_wdata;
  logic [c_SW-1:0]     r_wstrb;
  logic                r_arready, r_rvalid;
  logic [c_DW-1:0]     r_rdata;
  logic [1:0]          r_rresp;

  logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [31:0]         w_aw_idx, w_ar_idx, w_cidx;
  logic [c_DW-1:0]     w_cdata, w_rdata_mux;
  logic [c_SW-1:0]     w_cstrb;
  logic [1:0]          w_rresp_mux;
  logic                w_unused;

  assign w_aw_idx = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:c_ADDR_LSB]);
  assign w_ar_idx = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:c_ADDR_LSB]);
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[c_ADDR_LSB-1:0], S_AXI_ARADDR[c_ADDR_LSB-1:0]};

  assign w_aw_hs = r_awready & S_AXI_AWVALID;
  assign w_w_hs  = r_wready & S_AXI_WVALID;
  assign w_ar_hs = r_arready & S_AXI_ARVALID;

  // Commit uses the beat being accepted this cycle, else the latched one.
  assign w_cidx  = w_aw_hs ? w_aw_idx : r_widx;
  assign w_cdata = w_w_hs ? S_AXI_WDATA : r_wdata;
  assign w_cstrb = w_w_hs ? S_AXI_WSTRB : r_wstrb;

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_commit     = 1'b1;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_w_hs) begin
        w_wstate_nxt = W_RESP;
        w_commit     = 1'b1;
      end
      W_HAVE_W: if (w_aw_hs) begin
        w_wstate_nxt = W_RESP;
        w_commit     = 1'b1;
      end
      W_RESP: if (r_bvalid && S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_OKAY;
      r_widx    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_ctrl_wr <= '0;
      for (int k = 0; k < NUM_REGS; k++) r_ctrl[k] <= RESET_VAL;
    end else begin
      // Readies are decoded from the next state so they stay registered.
      r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_W);
      r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_AW);
      r_ctrl_wr <= '0;
      if (w_aw_hs) r_widx <= w_aw_idx;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_cidx >= c_NMAP) ? c_SLVERR : c_OKAY;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (w_cidx == 32'(k)) begin
            r_ctrl_wr[k] <= 1'b1;
            for (int b = 0; b < c_SW; b++) begin
              if (w_cstrb[b]) r_ctrl[k][b*8 +: 8] <= w_cdata[b*8 +: 8];
            end
          end
        end
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // ---------------- read channel ----------------
  always_comb begin
    w_rdata_mux = '0;
    w_rresp_mux = c_SLVERR;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_ar_idx == 32'(k)) begin
        w_rdata_mux = r_ctrl[k];
        w_rresp_mux = c_OKAY;
      end
    end
    for (int s = 0; s < NUM_STATUS; s++) begin
      if (w_ar_idx == 32'(NUM_REGS + s)) begin
        w_rdata_mux = status_in[s*c_DW +: c_DW];
        w_rresp_mux = c_OKAY;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
      R_RESP:  if (r_rvalid && S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= c_OKAY;
    end else begin
      r_arready <= (w_rstate_nxt == R_IDLE);
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata_mux;
        r_rresp  <= w_rresp_mux;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- outputs ----------------
  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign ctrl_wr       = r_ctrl_wr;

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_ctrl_flat
      assign ctrl_regs[k*c_DW +: c_DW] = r_ctrl[k];
    end
  endgenerate

endmodule
`default_nettype wire
